// File: rtl/present_pkg.sv
// Shared PRESENT S-box definitions: FSM state encoding, forward/inverse tables and lookups.
// Tables are packed with index 0 in the least-significant nibble.
package present_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] SBOX_FWD_TBL = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV_TBL = 64'hA970364BD21C8FE5;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] nib);
    return SBOX_FWD_TBL[{nib, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] nib);
    return SBOX_INV_TBL[{nib, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_sbox_lane.sv
// One combinational PRESENT S-box; inv_i selects the inverse table for decryption.
// Zero latency, no flow control.
module present_sbox_lane
  import present_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       inv_i,
  output logic [3:0] nib_o
);

  assign nib_o = inv_i ? sbox_inv(nib_i) : sbox_fwd(nib_i);

endmodule

// File: rtl/present_sbox_layer_seq.sv
// Multi-cycle PRESENT S-box layer: LANES nibbles per cycle, result after BEATS edges.
// Result is held in DONE until out_ready; a new block may be accepted on the same edge.
module present_sbox_layer_seq
  import present_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int NIB        = DATA_W / 4;
  localparam int LANES_SAFE = (LANES == 0) ? 1 : LANES;
  localparam int BEATS      = (NIB / LANES_SAFE == 0) ? 1 : NIB / LANES_SAFE;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW         = 4 * LANES_SAFE;

  if ((DATA_W % 4) != 0 || LANES == 0 || (NIB % LANES_SAFE) != 0) begin : g_bad_param
    $error("present_sbox_layer_seq: illegal DATA_W/LANES combination");
  end

  state_t             state_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  rot_d;
  logic [DATA_W-1:0]  out_q;
  logic [LW-1:0]      sub;
  logic [CNT_W-1:0]   cnt_q;
  logic               inv_q;
  logic               out_valid_q;

  for (genvar g = 0; g < LANES_SAFE; g++) begin : g_lane
    present_sbox_lane u_lane (
      .nib_i (data_q[4*g +: 4]),
      .inv_i (inv_q),
      .nib_o (sub[4*g +: 4])
    );
  end

  // Substituted low chunk lands at the top, so BEATS rotations restore nibble order.
  if (BEATS == 1) begin : g_rot_single
    assign rot_d = sub;
  end else begin : g_rot_multi
    assign rot_d = {sub, data_q[DATA_W-1:LW]};
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = (state_q == RUN) || (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            inv_q   <= in_inv;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          data_q <= rot_d;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            out_q       <= rot_d;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              data_q  <= in_data;
              inv_q   <= in_inv;
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
